// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scanner: hex glyph table,
// segment bit positions and the display frame record.
package seven_seg_pkg;

    localparam int MAX_DIGITS = 8;
    localparam int MAX_IDX_W  = 3;

    // Bit positions inside the 7-bit segment vector {g,f,e,d,c,b,a}.
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_ALL_OFF = 7'h00;

    // Entry n is the true-high glyph for hex digit n (0..9, A, b, C, d, E, F).
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // Sized for the widest display; unused upper digits stay zero.
    typedef struct packed {
        logic [MAX_DIGITS-1:0][3:0] nib;
        logic [MAX_DIGITS-1:0]      dp;
        logic [MAX_DIGITS-1:0]      blank;
    } frame_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        return HEX_SEG_TABLE[hex];
    endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to true-high seven-segment glyph.
module seg_hex_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex_to_seg(hex);
    end

endmodule

// File: rtl/seven_seg_mux.sv
// Time-multiplexed seven-segment display driver with frame-synchronous
// data updates and a one-cycle anode guard at every digit change.
module seven_seg_mux
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int CLK_DIV        = 100000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [4*NUM_DIGITS-1:0] wr_data,
    input  logic [NUM_DIGITS-1:0]   wr_dp,
    input  logic [NUM_DIGITS-1:0]   wr_blank,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    localparam logic [6:0]            SEG_OFF_LVL = {7{SEG_ACTIVE_LOW}};
    localparam logic                  DP_OFF_LVL  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF_LVL  = {NUM_DIGITS{AN_ACTIVE_LOW}};

    logic [PRE_W-1:0]     pre_cnt;
    logic [IDX_W-1:0]     digit_idx;
    logic                 tick;
    logic                 wrap_tick;

    frame_t               wr_frame;
    frame_t               pending_frame;
    frame_t               active_frame;
    logic                 pending_valid;

    logic [MAX_IDX_W-1:0] sel_idx;
    logic [3:0]           cur_nib;
    logic                 cur_dp;
    logic                 cur_blank;
    logic [6:0]           cur_glyph;

    logic [6:0]            seg_next;
    logic                  dp_next;
    logic [NUM_DIGITS-1:0] an_next;

    assign tick      = (pre_cnt == PRE_LAST);
    assign wrap_tick = tick && (digit_idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit_idx <= '0;
        end else if (wrap_tick) begin
            digit_idx <= '0;
        end else if (tick) begin
            digit_idx <= digit_idx + IDX_W'(1);
        end
    end

    always_comb begin
        wr_frame = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            wr_frame.nib[i]   = wr_data[4*i +: 4];
            wr_frame.dp[i]    = wr_dp[i];
            wr_frame.blank[i] = wr_blank[i];
        end
    end

    // Active data only changes at the frame boundary so a scan never mixes
    // old and new digits; a write landing on the boundary itself wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_frame <= '0;
            active_frame  <= '0;
            pending_valid <= 1'b0;
        end else if (wrap_tick) begin
            if (wr_en) begin
                active_frame <= wr_frame;
            end else if (pending_valid) begin
                active_frame <= pending_frame;
            end
            pending_valid <= 1'b0;
        end else if (wr_en) begin
            pending_frame <= wr_frame;
            pending_valid <= 1'b1;
        end
    end

    assign sel_idx   = MAX_IDX_W'(digit_idx);
    assign cur_nib   = active_frame.nib[sel_idx];
    assign cur_dp    = active_frame.dp[sel_idx];
    assign cur_blank = active_frame.blank[sel_idx];

    seg_hex_decoder u_hex_decoder (
        .hex (cur_nib),
        .seg (cur_glyph)
    );

    always_comb begin
        seg_next = SEG_ALL_OFF;
        dp_next  = 1'b0;
        an_next  = '0;
        if (!cur_blank) begin
            seg_next = cur_glyph;
            dp_next  = cur_dp;
        end
        // Anodes stay dark across the digit switch to avoid ghosting.
        if (!tick) begin
            an_next = NUM_DIGITS'(1) << digit_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg        <= SEG_OFF_LVL;
            dp         <= DP_OFF_LVL;
            an         <= AN_OFF_LVL;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_next ^ {7{SEG_ACTIVE_LOW}};
            dp         <= dp_next ^ SEG_ACTIVE_LOW;
            an         <= an_next ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
            frame_done <= wrap_tick;
        end
    end

endmodule

// File: tb/tb_seven_seg_mux.sv
// Scoreboard bench for seven_seg_mux: a time-based reference model predicts
// every output register value; a monitor compares each cycle.
module tb_seven_seg_mux;

    localparam int ND    = 4;
    localparam int CD    = 4;
    localparam int FRAME = ND * CD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic [3:0]  wr_dp = '0;
    logic [3:0]  wr_blank = '0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    always #5 clk = ~clk;

    seven_seg_mux #(
        .NUM_DIGITS     (ND),
        .CLK_DIV        (CD),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_dp      (wr_dp),
        .wr_blank   (wr_blank),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       fd;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference state: elapsed cycles since reset plus shown/queued digit data.
    int         t = 0;
    logic [3:0] act_nib [ND];
    logic [3:0] pend_nib [ND];
    logic [3:0] act_dp, act_bl, pend_dp, pend_bl;
    bit         pend_v;

    task automatic model_reset();
        for (int i = 0; i < ND; i++) begin
            act_nib[i]  = '0;
            pend_nib[i] = '0;
        end
        act_dp = '0; act_bl = '0; pend_dp = '0; pend_bl = '0;
        pend_v = 0;
        t = 0;
    endtask

    task automatic step(input bit r, input bit en, input logic [15:0] d,
                        input logic [3:0] p, input logic [3:0] b);
        obs_t e;
        int   idx;
        bit   tick, wrap;
        logic [6:0] s;
        logic       dpv;
        logic [3:0] anv;
        @(negedge clk);
        rst_n = r; wr_en = en; wr_data = d; wr_dp = p; wr_blank = b;
        if (!r) begin
            e = '{seg: 7'h7F, dp: 1'b1, an: 4'hF, fd: 1'b0};
            model_reset();
        end else begin
            idx  = (t / CD) % ND;
            tick = (t % CD) == CD - 1;
            wrap = tick && (idx == ND - 1);
            s    = act_bl[idx] ? 7'h00 : glyph[act_nib[idx]];
            dpv  = !act_bl[idx] && act_dp[idx];
            anv  = tick ? 4'h0 : 4'(1 << idx);
            e    = '{seg: ~s, dp: ~dpv, an: ~anv, fd: wrap};
            if (wrap) begin
                if (en) begin
                    for (int i = 0; i < ND; i++) act_nib[i] = d[4*i +: 4];
                    act_dp = p; act_bl = b;
                end else if (pend_v) begin
                    act_nib = pend_nib; act_dp = pend_dp; act_bl = pend_bl;
                end
                pend_v = 0;
            end else if (en) begin
                for (int i = 0; i < ND; i++) pend_nib[i] = d[4*i +: 4];
                pend_dp = p; pend_bl = b;
                pend_v = 1;
            end
            t++;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 16'h0, 4'h0, 4'h0);
    endtask

    task automatic idle_until(input int phase);
        for (int i = 0; i < FRAME && (t % FRAME) != phase; i++) step(1, 0, 16'h0, 4'h0, 4'h0);
    endtask

    initial begin : monitor
        obs_t e, g;
        int   cyc;
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = '{seg: seg, dp: dp, an: an, fd: frame_done};
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d seg got %h exp %h dp got %b exp %b an got %h exp %h frame_done got %b exp %b",
                             cyc, g.seg, e.seg, g.dp, e.dp, g.an, e.an, g.fd, e.fd);
                end
                cyc++;
            end
        end
    end

    initial begin : stimulus
        model_reset();
        step(0, 0, 16'h0, 4'h0, 4'h0);
        step(0, 0, 16'h0, 4'h0, 4'h0);
        idle(2 * FRAME);

        // mid-frame write of 3210
        idle_until(5);
        step(1, 1, 16'h3210, 4'h0, 4'h0);
        idle(2 * FRAME);

        // two writes in one frame: last one wins
        idle_until(2);
        step(1, 1, 16'h1111, 4'h0, 4'h0);
        idle(4);
        step(1, 1, 16'hABCD, 4'h0, 4'h0);
        idle(2 * FRAME);

        // stale pending then a write exactly on the wrap tick
        idle_until(3);
        step(1, 1, 16'h5555, 4'h0, 4'h0);
        idle_until(FRAME - 1);
        step(1, 1, 16'hFFFF, 4'h0, 4'h0);
        idle(2 * FRAME);

        // blank digit 2, decimal points on digits 0 and 2
        idle_until(7);
        step(1, 1, 16'h4321, 4'b0101, 4'b0100);
        idle(2 * FRAME);

        // one-cycle reset mid-frame with a pending write outstanding
        idle_until(6);
        step(1, 1, 16'h9876, 4'hF, 4'h0);
        idle(3);
        step(0, 0, 16'h0, 4'h0, 4'h0);
        idle(2 * FRAME);

        for (int i = 0; i < 1500; i++) begin
            bit r, en;
            r  = ($urandom_range(0, 199) != 0);
            en = ($urandom_range(0, 3) == 0);
            step(r, en, 16'($urandom), 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0));
        end
        idle(FRAME);

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain leftover %0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
